ram_ctrl: RTL

//  Parametrised synchronous data memory for the RISC datapath with a rd/wr request,

---
 rtl/ram_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/ram_ctrl.sv
// Synchronous data memory with rd/wr request, busy/done handshake, programmable wait
// states and per-byte write enables. One request in flight; inputs ignored while busy.
module ram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                rd,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   dout,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int NB     = DATA_W / 8;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              accept, access_fire;
  logic              op_wr_reg, bad_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] din_reg;
  logic [NB-1:0]     be_reg;
  logic [MEM_AW-1:0] mem_addr;
  logic              wr_fire, rd_fire;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    accept      = 1'b0;
    access_fire = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (rd || wr) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = S_WAIT;
            cnt_next   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_next = S_ACCESS;
            cnt_next   = 4'd0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) state_next = S_ACCESS;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_ACCESS: begin
        access_fire = 1'b1;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done      <= access_fire;
      err       <= access_fire & bad_reg;
      if (accept)           busy <= 1'b1;
      else if (access_fire) busy <= 1'b0;
    end
  end

  // Request fields are only captured on acceptance, so activity while busy is inert.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_wr_reg <= wr;
      bad_reg   <= (rd & wr) | (32'(addr) >= DEPTH);
      addr_reg  <= addr;
      din_reg   <= din;
      be_reg    <= be;
    end
  end

  assign mem_addr = addr_reg[MEM_AW-1:0];
  assign wr_fire  = access_fire & op_wr_reg & ~bad_reg & ~clear;
  assign rd_fire  = access_fire & ~op_wr_reg & ~bad_reg;

  // One narrow array per byte lane keeps byte writes a plain enable per RAM.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [0:DEPTH-1];
    logic [7:0] lane_dout_reg;

    always_ff @(posedge clock) begin
      if (wr_fire && be_reg[gi]) lane_mem[mem_addr] <= din_reg[8*gi +: 8];
    end

    always_ff @(posedge clock) begin
      if (clear)        lane_dout_reg <= 8'd0;
      else if (rd_fire) lane_dout_reg <= lane_mem[mem_addr];
    end

    assign dout[8*gi +: 8] = lane_dout_reg;
  end

endmodule
